pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, giving post-decode stages tracked (1=EX, 2=MEM, 3=WB).
REQ-002 SHALL have parameter NSRC, default 2, giving source operands per decoded instruction.
REQ-003 SHALL have parameter REG_AW, default 5, giving register address width.
REQ-004 SHALL have parameter LOAD_STAGE, default 2, giving the first stage at which load data is forwardable (range 1..NSTAGE).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 id_valid  in  1  decode slot holds a real instruction.
REQ-009 id_rs_addr  in  NSRC*REG_AW  source register addresses, source 0 in LSBs.
REQ-010 id_rs_used  in  NSRC  source actually read.
REQ-011 id_rd, id_rd_wen, id_is_load  in  REG_AW/1/1  destination, writes regfile, is load.
REQ-012 redirect  in  1  taken branch/jump resolved this cycle; decode-slot instruction is wrong-path.
REQ-013 ext_stall  in  1  memory/backend busy; whole pipeline freezes.
REQ-014 fwd_sel  out  NSRC*SELW  per source: 0 = register file, k = stage k; SELW = clog2(NSTAGE+1).
REQ-015 hold_front  out  1  hold PC and IF/ID register.
REQ-016 bubble_ex  out  1  load a bubble into ID/EX.
REQ-017 flush_id  out  1  clear IF/ID register to a bubble.
REQ-018 stall_cnt, flush_cnt  out  32/32  performance counters (REQ-036).

Function
REQ-019 SHALL keep a tracking shift register of NSTAGE entries {valid, rd, wen, is_load}; entry k mirrors stage k.
REQ-020 Per source with id_rs_used=1 and addr!=0, SHALL find the lowest k with entry valid & wen & rd==addr (youngest wins).
REQ-021 Match at k, non-load or k>=LOAD_STAGE: fwd_sel=k; no match, addr==0 or source unused: fwd_sel=0.
REQ-022 Match at k on a load with k<LOAD_STAGE: load-use hazard; fwd_sel=0 for that source.
REQ-023 Load-use hazard with id_valid=1, redirect=0: hold_front=1, bubble_ex=1, flush_id=0.
REQ-024 redirect=1 SHALL take priority over load-use: flush_id=1, bubble_ex=1, hold_front=0.
REQ-025 ext_stall=1 SHALL freeze the tracking register and force hold_front=1, bubble_ex=0, flush_id=0, regardless of other inputs; sources hold redirect until ext_stall drops.
REQ-026 Each unfrozen cycle: entry[k] <= entry[k-1] for k>=2; entry[1] <= decode fields if id_valid & !bubble_ex, else invalid.
REQ-027 Outputs except counters SHALL be combinational from inputs and tracking state; hazard-to-stall latency 0 cycles.
REQ-028 A load-use stall SHALL last exactly LOAD_STAGE-k cycles for a match at stage k, then forward from stage LOAD_STAGE.
REQ-029 Two sources matching different stages SHALL resolve independently; any stalling source stalls the instruction.

Reset
REQ-030 On rst=1 at a clock edge, all entries SHALL become invalid.
REQ-031 After reset: fwd_sel=0, hold_front=0, bubble_ex=0, flush_id=0, counters=0.
REQ-032 Reset mid-stall SHALL discard the hazard; first post-reset cycle sees no stall.
REQ-033 rst SHALL dominate ext_stall and redirect.

Configuration
REQ-034 Macro HAZARD_PERF_EN SHALL gate the performance counters.
REQ-035 Defined: stall_cnt +1 per load-use stall cycle, flush_cnt +1 per redirect cycle (both only when ext_stall=0), saturating at 0xFFFFFFFF.
REQ-036 Undefined: stall_cnt and flush_cnt SHALL be constant 0, with no counter flops.

Structure
REQ-037 Package pipe_hazard_pkg SHALL hold the tracking-entry struct typedef, the FWD_RF=0 constant, and the SELW function.
REQ-038 One sub-module hazard_fwd_lookup (per-source youngest-match search), instantiated NSRC times.

Verification
REQ-039 ADD x5 then ADD reading x5 next cycle -> fwd_sel[src0]=1, no stall.
REQ-040 LW x6 then ADD reading x6 (LOAD_STAGE=2) -> one cycle hold_front=1/bubble_ex=1, then fwd_sel=2.
REQ-041 x7 written at stages 1 and 3, ID reads x7 -> fwd_sel=1 (youngest).
REQ-042 Load-use and redirect in the same cycle -> flush_id=1, bubble_ex=1, hold_front=0; flush_cnt +1, stall_cnt unchanged.
REQ-043 ext_stall held 3 cycles during a load-use hazard -> tracking frozen, hold_front=1, bubble_ex=0; after release, the stall completes in 1 cycle.
REQ-044 rst asserted mid-stall, reading x0 -> all outputs 0; x0 reads never forward or stall.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Tracking entries store rd zero-extended to MAX_REG_AW bits so the struct is width-independent.
package pipe_hazard_pkg;

  localparam int MAX_REG_AW = 16;
  localparam int FWD_RF     = 0;

  typedef logic [MAX_REG_AW-1:0] trk_rd_t;

  typedef struct packed {
    logic    valid;
    trk_rd_t rd;
    logic    wen;
    logic    is_load;
  } trk_entry_t;

  function automatic int selw(input int nstage);
    return (nstage < 1) ? 1 : $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_lookup.sv
// Youngest-match forwarding search for one source operand over the tracked stages.
// Flags a load-use hazard when the youngest producer is a load not yet forwardable.
module hazard_fwd_lookup
  import pipe_hazard_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = selw(NSTAGE)
) (
  input  trk_entry_t [NSTAGE-1:0] trk,
  input  logic [REG_AW-1:0]       rs_addr,
  input  logic                    rs_used,
  output logic [SELW-1:0]         sel,
  output logic                    load_use
);

  logic            active;
  logic            hit;
  logic            hit_load;
  logic [SELW-1:0] hit_k;

  assign active = rs_used && (rs_addr != '0);

  // Scan oldest to youngest so the lowest matching stage overwrites older hits.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (trk[k-1].valid && trk[k-1].wen && (trk[k-1].rd == trk_rd_t'(rs_addr))) begin
        hit      = 1'b1;
        hit_load = trk[k-1].is_load;
        hit_k    = SELW'(k);
      end
    end
  end

  assign load_use = active && hit && hit_load && (int'(hit_k) < LOAD_STAGE);
  assign sel      = (active && hit && !load_use) ? hit_k : SELW'(FWD_RF);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding select, load-use stall and redirect flush control for an in-order pipeline.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int NSRC       = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [NSRC*REG_AW-1:0]          id_rs_addr,
  input  logic [NSRC-1:0]                 id_rs_used,
  input  logic [REG_AW-1:0]               id_rd,
  input  logic                            id_rd_wen,
  input  logic                            id_is_load,
  input  logic                            redirect,
  input  logic                            ext_stall,
  output logic [NSRC*selw(NSTAGE)-1:0]    fwd_sel,
  output logic                            hold_front,
  output logic                            bubble_ex,
  output logic                            flush_id,
  output logic [31:0]                     stall_cnt,
  output logic [31:0]                     flush_cnt
);

  localparam int SELW = selw(NSTAGE);

  trk_entry_t [NSTAGE-1:0]     trk_reg;
  logic [NSRC-1:0][SELW-1:0]   src_sel;
  logic [NSRC-1:0]             src_load_use;
  logic                        load_use_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      hazard_fwd_lookup #(
        .NSTAGE     (NSTAGE),
        .REG_AW     (REG_AW),
        .LOAD_STAGE (LOAD_STAGE),
        .SELW       (SELW)
      ) u_lookup (
        .trk      (trk_reg),
        .rs_addr  (id_rs_addr[gi*REG_AW +: REG_AW]),
        .rs_used  (id_rs_used[gi]),
        .sel      (src_sel[gi]),
        .load_use (src_load_use[gi])
      );
      assign fwd_sel[gi*SELW +: SELW] = rst ? SELW'(FWD_RF) : src_sel[gi];
    end
  endgenerate

  assign load_use_stall = id_valid && (|src_load_use) && !redirect;

  // Priority: reset, then backend freeze, then redirect, then load-use.
  always_comb begin
    hold_front = 1'b0;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;
    if (rst) begin
      hold_front = 1'b0;
    end else if (ext_stall) begin
      hold_front = 1'b1;
    end else if (redirect) begin
      flush_id   = 1'b1;
      bubble_ex  = 1'b1;
    end else if (load_use_stall) begin
      hold_front = 1'b1;
      bubble_ex  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_reg <= '0;
    end else if (!ext_stall) begin
      for (int k = 1; k < NSTAGE; k++) begin
        trk_reg[k] <= trk_reg[k-1];
      end
      if (id_valid && !bubble_ex) begin
        trk_reg[0] <= '{valid: 1'b1, rd: trk_rd_t'(id_rd), wen: id_rd_wen, is_load: id_is_load};
      end else begin
        trk_reg[0] <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!ext_stall) begin
      if (load_use_stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (redirect && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default parameters.
// Counter expectations follow HAZARD_PERF_EN: counts when defined, constant zero otherwise.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam int unsigned PERF = 1;
`else
  localparam int unsigned PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_rd_wen;
  logic        id_is_load;
  logic        redirect;
  logic        ext_stall;
  logic [3:0]  fwd_sel;
  logic        hold_front;
  logic        bubble_ex;
  logic        flush_id;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NSTAGE     (3),
    .NSRC       (2),
    .REG_AW     (5),
    .LOAD_STAGE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs_addr (id_rs_addr),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_rd_wen  (id_rd_wen),
    .id_is_load (id_is_load),
    .redirect   (redirect),
    .ext_stall  (ext_stall),
    .fwd_sel    (fwd_sel),
    .hold_front (hold_front),
    .bubble_ex  (bubble_ex),
    .flush_id   (flush_id),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic wen,
                       input logic ld);
    id_valid   = v;
    id_rs_addr = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_rd_wen  = wen;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_stall = 1'b1; redirect = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    checks++; if (hold_front !== 1'b0) begin errors++; $display("FAIL rst_dom_hold: got %b exp 0", hold_front); end
    checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL rst_dom_flush: got %b exp 0", flush_id); end
    step(); step();
    rst = 1'b0; ext_stall = 1'b0; redirect = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL reset_fwd: got %h exp 0", fwd_sel); end
    checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b exp 000", {hold_front, bubble_ex, flush_id}); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d exp 0", flush_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_alu_forward();
    idle();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 2'b11, 5'd1, 1'b1, 1'b0);
    checks++; if (fwd_sel !== 4'h1) begin errors++; $display("FAIL alu_fwd_ex: got %h exp 1", fwd_sel); end
    checks++; if ({hold_front, bubble_ex} !== 2'b00) begin errors++; $display("FAIL alu_no_stall: got %b exp 00", {hold_front, bubble_ex}); end
    step();
    drive(1'b1, 5'd0, 5'd5, 2'b10, 5'd2, 1'b0, 1'b0);
    checks++; if (fwd_sel !== 4'h8) begin errors++; $display("FAIL alu_fwd_mem_src1: got %h exp 8", fwd_sel); end
    drive(1'b1, 5'd5, 5'd5, 2'b00, 5'd2, 1'b0, 1'b0);
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL alu_unused_src: got %h exp 0", fwd_sel); end
    $display("test_alu_forward done");
  endtask

  task automatic test_load_use();
    idle();
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0);
    checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b110) begin errors++; $display("FAIL lu_stall: got %b exp 110", {hold_front, bubble_ex, flush_id}); end
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL lu_fwd_during: got %h exp 0", fwd_sel); end
    step();
    exp_stall += PERF;
    checks++; if ({hold_front, bubble_ex} !== 2'b00) begin errors++; $display("FAIL lu_release: got %b exp 00", {hold_front, bubble_ex}); end
    checks++; if (fwd_sel !== 4'h2) begin errors++; $display("FAIL lu_fwd_after: got %h exp 2", fwd_sel); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
    $display("test_load_use done");
  endtask

  task automatic test_youngest();
    idle();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0); step();
    drive(1'b1, 5'd7, 5'd8, 2'b11, 5'd9, 1'b1, 1'b0);
    checks++; if (fwd_sel !== 4'h9) begin errors++; $display("FAIL youngest_fwd: got %h exp 9", fwd_sel); end
    checks++; if (hold_front !== 1'b0) begin errors++; $display("FAIL youngest_hold: got %b exp 0", hold_front); end
    $display("test_youngest done");
  endtask

  task automatic test_independent();
    idle();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1); step();
    drive(1'b1, 5'd11, 5'd10, 2'b11, 5'd12, 1'b1, 1'b0);
    checks++; if ({hold_front, bubble_ex} !== 2'b11) begin errors++; $display("FAIL indep_stall: got %b exp 11", {hold_front, bubble_ex}); end
    checks++; if (fwd_sel !== 4'h2) begin errors++; $display("FAIL indep_fwd_during: got %h exp 2", fwd_sel); end
    step();
    exp_stall += PERF;
    checks++; if (hold_front !== 1'b0) begin errors++; $display("FAIL indep_release: got %b exp 0", hold_front); end
    checks++; if (fwd_sel !== 4'hB) begin errors++; $display("FAIL indep_fwd_after: got %h exp b", fwd_sel); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL indep_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
    $display("test_independent done");
  endtask

  task automatic test_redirect();
    idle();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1); step();
    redirect = 1'b1;
    drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd20, 1'b1, 1'b0);
    checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b011) begin errors++; $display("FAIL redir_prio: got %b exp 011", {hold_front, bubble_ex, flush_id}); end
    step();
    exp_flush += PERF;
    redirect = 1'b0;
    drive(1'b1, 5'd20, 5'd0, 2'b01, 5'd21, 1'b1, 1'b0);
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL redir_wrong_path: got %h exp 0", fwd_sel); end
    checks++; if (flush_cnt !== exp_flush) begin errors++; $display("FAIL redir_flush_cnt: got %0d exp %0d", flush_cnt, exp_flush); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL redir_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
    $display("test_redirect done");
  endtask

  task automatic test_ext_stall();
    idle();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b1); step();
    ext_stall = 1'b1;
    drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b100) begin errors++; $display("FAIL xs_freeze_c%0d: got %b exp 100", c, {hold_front, bubble_ex, flush_id}); end
      step();
    end
    ext_stall = 1'b0;
    #1;
    checks++; if ({hold_front, bubble_ex} !== 2'b11) begin errors++; $display("FAIL xs_stall_after: got %b exp 11", {hold_front, bubble_ex}); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL xs_cnt_frozen: got %0d exp %0d", stall_cnt, exp_stall); end
    step();
    exp_stall += PERF;
    checks++; if (hold_front !== 1'b0 || fwd_sel !== 4'h2) begin errors++; $display("FAIL xs_complete: got hold=%b fwd=%h exp hold=0 fwd=2", hold_front, fwd_sel); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL xs_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall); end
    $display("test_ext_stall done");
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b1); step();
    drive(1'b1, 5'd13, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
    checks++; if (hold_front !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %b exp 1", hold_front); end
    rst = 1'b1;
    #1;
    checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b000 || fwd_sel !== 4'h0) begin errors++; $display("FAIL rms_during: got ctrl=%b fwd=%h exp 000/0", {hold_front, bubble_ex, flush_id}, fwd_sel); end
    step();
    rst = 1'b0;
    exp_stall = 0; exp_flush = 0;
    #1;
    checks++; if ({hold_front, bubble_ex, flush_id} !== 3'b000 || fwd_sel !== 4'h0) begin errors++; $display("FAIL rms_post: got ctrl=%b fwd=%h exp 000/0", {hold_front, bubble_ex, flush_id}, fwd_sel); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rms_cnts: got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1); step();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd15, 1'b1, 1'b0);
    checks++; if (hold_front !== 1'b0 || fwd_sel !== 4'h0) begin errors++; $display("FAIL x0_no_hazard: got hold=%b fwd=%h exp 0/0", hold_front, fwd_sel); end
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; ext_stall = 1'b0;
    id_valid = 1'b0; id_rs_addr = '0; id_rs_used = '0;
    id_rd = '0; id_rd_wen = 1'b0; id_is_load = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_independent();
    test_redirect();
    test_ext_stall();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
